// File: rtl/risc_mmio_responder_if.sv
// risc_mmio_responder_if: CPU data-port and transmit-stream signals of the MMIO responder
// master: CPU/consumer side (drives store strobe, address, data, Out_Ready)
// slave: responder side (drives Dev_Hit, Dev_Data_Out, Out_Valid, Out_Data, Timer_Irq)
interface risc_mmio_responder_if;
  logic        EX_WB_MW;
  logic [31:0] EX_WB_Data_Mem_Addr;
  logic [31:0] Ex_WB_Data_Mem_Data_In;
  logic        Dev_Hit;
  logic [31:0] Dev_Data_Out;
  logic        Out_Valid;
  logic [31:0] Out_Data;
  logic        Out_Ready;
  logic        Timer_Irq;
  modport master (
    output EX_WB_MW, EX_WB_Data_Mem_Addr, Ex_WB_Data_Mem_Data_In, Out_Ready,
    input  Dev_Hit, Dev_Data_Out, Out_Valid, Out_Data, Timer_Irq
  );
  modport slave (
    input  EX_WB_MW, EX_WB_Data_Mem_Addr, Ex_WB_Data_Mem_Data_In, Out_Ready,
    output Dev_Hit, Dev_Data_Out, Out_Valid, Out_Data, Timer_Irq
  );
endinterface

// File: rtl/risc_mmio_responder.sv
// risc_mmio_responder: 256-byte MMIO window with transmit FIFO and interval timer
// clk, reset: system clock and synchronous active-high reset
// bus: CPU store/load port, FIFO valid/ready drain, timer interrupt
module risc_mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 4
) (
  input logic                clk,
  input logic                reset,
  risc_mmio_responder_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]    rptr, wptr;
  logic [CNT_W-1:0] count;
  logic             ovf, flag;
  logic [1:0]       ctrl;
  logic [31:0]      tcount, tcmp, status, wdata;
  logic [5:0]       off;
  logic             hit, wr, empty, full, pop, push, accept, drop, st_wr, tcmp_wr, match;
  assign wdata   = bus.Ex_WB_Data_Mem_Data_In;
  assign hit     = bus.EX_WB_Data_Mem_Addr[31:8] == BASE_ADDR[31:8];
  assign off     = bus.EX_WB_Data_Mem_Addr[7:2];
  assign wr      = bus.EX_WB_MW & hit;
  assign empty   = count == '0;
  assign full    = count == CNT_W'(FIFO_DEPTH);
  assign pop     = bus.Out_Valid & bus.Out_Ready;
  assign push    = wr & (off == 6'd0);
  // a pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign accept  = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign st_wr   = wr & (off == 6'd1);
  assign tcmp_wr = wr & (off == 6'd3);
  assign match   = ctrl[0] & (tcount == tcmp);
  assign status  = (32'(count) << 8) | {28'b0, flag, ovf, full, empty};
  assign bus.Dev_Hit      = hit;
  assign bus.Out_Valid    = ~empty;
  assign bus.Out_Data     = empty ? '0 : mem[rptr];
  assign bus.Timer_Irq    = flag & ctrl[1];
  assign bus.Dev_Data_Out = !hit           ? '0 :
                            off == 6'd0    ? bus.Out_Data :
                            off == 6'd1    ? status :
                            off == 6'd2    ? tcount :
                            off == 6'd3    ? tcmp :
                            off == 6'd4    ? {30'b0, ctrl} : '0;
  always_ff @(posedge clk)
    if (accept) mem[wptr] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      flag   <= 1'b0;
      tcount <= '0;
      tcmp   <= '0;
      ctrl   <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count  <= count + CNT_W'(accept) - CNT_W'(pop);
      // hardware set beats a simultaneous write-1-to-clear
      ovf    <= drop | (ovf & ~(st_wr & wdata[2]));
      flag   <= (match & ~tcmp_wr) | (flag & ~(st_wr & wdata[3]));
      tcount <= (tcmp_wr | match) ? '0 : ctrl[0] ? tcount + 32'd1 : tcount;
      if (tcmp_wr) tcmp <= wdata;
      if (wr & (off == 6'd4)) ctrl <= wdata[1:0];
    end
  end
endmodule

// File: tb/tb_risc_mmio_responder.sv
// tb_risc_mmio_responder: scoreboard bench with a queue-based reference model
module tb_risc_mmio_responder;
  logic clk, reset;
  risc_mmio_responder_if bus();
  risc_mmio_responder dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, failures = 0;
  logic rdy = 1'b0;
  logic [31:0] m_fifo[$], sb_q[$];
  logic        m_ovf = 1'b0, m_flag = 1'b0;
  logic [31:0] m_tcount = '0, m_tcmp = '0;
  logic [1:0]  m_ctrl = '0;
  logic [31:0] ma, md;
  logic [5:0]  mo;
  logic        mw, mp, set_f, set_o;
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [5:0] o;
    o = a[7:2];
    if (a[31:8] != 24'hFFFFFF) return 32'h0;
    case (o)
      6'd0: return m_fifo.size() != 0 ? m_fifo[0] : 32'h0;
      6'd1: return {20'b0, 4'(m_fifo.size()), 4'b0, m_flag, m_ovf, m_fifo.size() == 8, m_fifo.size() == 0};
      6'd2: return m_tcount;
      6'd3: return m_tcmp;
      6'd4: return {30'b0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction
  always @(posedge clk) begin
    ma = bus.EX_WB_Data_Mem_Addr;
    md = bus.Ex_WB_Data_Mem_Data_In;
    mo = ma[7:2];
    mw = bus.EX_WB_MW && ma[31:8] == 24'hFFFFFF;
    mp = m_fifo.size() != 0 && bus.Out_Ready;
    set_f = 1'b0;
    set_o = 1'b0;
    if (reset) begin
      m_fifo.delete();
      sb_q.delete();
      m_ovf = 1'b0;
      m_flag = 1'b0;
      m_tcount = '0;
      m_tcmp = '0;
      m_ctrl = '0;
    end else begin
      if (mw && mo == 6'd0) begin
        if (m_fifo.size() < 8 || mp) begin
          m_fifo.push_back(md);
          sb_q.push_back(md);
        end else set_o = 1'b1;
      end
      if (mp) void'(m_fifo.pop_front());
      if (mw && mo == 6'd3) begin
        m_tcount = '0;
        m_tcmp = md;
      end else if (m_ctrl[0] && m_tcount == m_tcmp) begin
        m_tcount = '0;
        set_f = 1'b1;
      end else if (m_ctrl[0]) m_tcount++;
      if (mw && mo == 6'd1) begin
        if (md[2]) m_ovf = 1'b0;
        if (md[3]) m_flag = 1'b0;
      end
      if (set_o) m_ovf = 1'b1;
      if (set_f) m_flag = 1'b1;
      if (mw && mo == 6'd4) m_ctrl = md[1:0];
    end
  end
  always @(negedge clk) begin
    chk("dev_hit", 32'(bus.Dev_Hit), 32'(bus.EX_WB_Data_Mem_Addr[31:8] == 24'hFFFFFF));
    chk("dev_data", bus.Dev_Data_Out, mread(bus.EX_WB_Data_Mem_Addr));
    chk("out_valid", 32'(bus.Out_Valid), 32'(m_fifo.size() != 0));
    chk("timer_irq", 32'(bus.Timer_Irq), 32'(m_flag & m_ctrl[1]));
    if (bus.Out_Valid && bus.Out_Ready) begin
      if (sb_q.size() == 0) chk("sb_underflow", bus.Out_Data, 32'hDEAD_BEEF);
      else chk("out_data", bus.Out_Data, sb_q.pop_front());
    end else if (!bus.Out_Valid) chk("out_data_empty", bus.Out_Data, 32'h0);
  end
  task automatic step(input logic m, input logic [31:0] a, input logic [31:0] d, input logic r, input logic rs);
    bus.EX_WB_MW = m;
    bus.EX_WB_Data_Mem_Addr = a;
    bus.Ex_WB_Data_Mem_Data_In = d;
    bus.Out_Ready = r;
    reset = rs;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] o, input logic [31:0] d);
    step(1'b1, {24'hFFFFFF, o}, d, rdy, 1'b0);
  endtask
  task automatic idle();
    step(1'b0, 32'hFFFF_FF04, 32'h0, rdy, 1'b0);
  endtask
  task automatic rd(input string n, input logic [7:0] o, input logic [31:0] exp);
    bus.EX_WB_MW = 1'b0;
    bus.EX_WB_Data_Mem_Addr = {24'hFFFFFF, o};
    bus.Out_Ready = rdy;
    #1;
    chk(n, bus.Dev_Data_Out, exp);
  endtask
  initial begin
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    rd("reset_status", 8'h04, 32'h1);
    chk("reset_valid", 32'(bus.Out_Valid), 32'h0);
    chk("reset_data", bus.Out_Data, 32'h0);
    chk("reset_irq", 32'(bus.Timer_Irq), 32'h0);
    for (int i = 1; i <= 3; i++) wr(8'h00, 32'hA5A5_0000 + 32'(i));
    rd("status_3", 8'h04, 32'h300);
    rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      rd("head_peek", 8'h00, 32'hA5A5_0000 + 32'(i));
      chk("head_order", bus.Out_Data, 32'hA5A5_0000 + 32'(i));
      idle();
    end
    chk("drained_valid", 32'(bus.Out_Valid), 32'h0);
    rdy = 1'b0;
    for (int i = 0; i < 9; i++) wr(8'h00, 32'hC000_0000 + 32'(i));
    rd("status_full_ovf", 8'h04, 32'h806);
    rdy = 1'b1;
    wr(8'h00, 32'hD00D_0001);
    rdy = 1'b0;
    rd("status_full_pushpop", 8'h04, 32'h806);
    wr(8'h04, 32'h4);
    rd("status_ovf_clr", 8'h04, 32'h802);
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) idle();
    rdy = 1'b0;
    chk("full_drained", 32'(bus.Out_Valid), 32'h0);
    wr(8'h0C, 32'd3);
    wr(8'h10, 32'h3);
    for (int i = 0; i <= 4; i++) begin
      rd("tcount_seq", 8'h08, i == 4 ? 32'h0 : 32'(i));
      chk("irq_seq", 32'(bus.Timer_Irq), 32'(i == 4));
      if (i < 4) idle();
    end
    wr(8'h04, 32'h8);
    chk("irq_w1c", 32'(bus.Timer_Irq), 32'h0);
    rd("tcount_after_w1c", 8'h08, 32'd1);
    idle();
    idle();
    wr(8'h04, 32'h8);
    chk("irq_set_wins", 32'(bus.Timer_Irq), 32'h1);
    rd("tcount_wrap", 8'h08, 32'h0);
    bus.EX_WB_MW = 1'b1;
    bus.EX_WB_Data_Mem_Addr = 32'h0000_0040;
    bus.Ex_WB_Data_Mem_Data_In = 32'hFFFF_FFFF;
    #1;
    chk("hit_outside", 32'(bus.Dev_Hit), 32'h0);
    chk("data_outside", bus.Dev_Data_Out, 32'h0);
    @(posedge clk);
    #1;
    rd("ctrl_kept", 8'h10, 32'h3);
    rd("tcmp_kept", 8'h0C, 32'h3);
    rd("unmapped", 8'h20, 32'h0);
    for (int i = 0; i < 5; i++) wr(8'h00, 32'hE000_0000 + 32'(i));
    chk("queued_valid", 32'(bus.Out_Valid), 32'h1);
    step(1'b0, 32'hFFFF_FF04, 32'h0, 1'b0, 1'b1);
    rd("rst_status", 8'h04, 32'h1);
    rd("rst_tcount", 8'h08, 32'h0);
    rd("rst_tcmp", 8'h0C, 32'h0);
    rd("rst_ctrl", 8'h10, 32'h0);
    chk("rst_valid", 32'(bus.Out_Valid), 32'h0);
    chk("rst_irq", 32'(bus.Timer_Irq), 32'h0);
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [31:0] a, d;
      sel = $urandom_range(0, 9);
      a = sel == 9 ? 32'($urandom) :
          32'hFFFF_FF00 | (32'(sel < 4 ? 0 : sel - 3) << 2) | 32'($urandom_range(0, 3));
      d = 32'($urandom);
      if (a[7:2] == 6'd3) d = 32'($urandom_range(0, 12));
      if (a[7:2] == 6'd1 && $urandom_range(0, 3) != 0) d = 32'h0;
      rdy = $urandom_range(0, 99) < ((i / 500) % 2 == 1 ? 5 : 60);
      step(1'($urandom_range(0, 1)), a, d, rdy, $urandom_range(0, 299) == 0);
    end
    step(1'b0, 32'hFFFF_FF04, 32'h0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
